// File: rtl/sne_evt_stream_pkg.sv
// Shared types for the SNE event stream.
// Provides the event word layout, the event opcodes, the timestamp type and
// the state encoding of the spike encoder FSM. The spike_evt_t struct matches
// the default group geometry (16 neurons, 8-bit group index).
package sne_evt_stream_pkg;

  localparam int unsigned TIME_W          = 16;
  localparam int unsigned EVT_NUM_NEURONS = 16;
  localparam int unsigned EVT_NID_W       = $clog2(EVT_NUM_NEURONS);
  localparam int unsigned EVT_GID_W       = 8;

  typedef logic [TIME_W-1:0] timestamp_t;

  typedef enum logic [1:0] {
    EVT_SPIKE = 2'b01,
    EVT_EOS   = 2'b10
  } evt_op_e;

  // Event word, MSB first: op, gid, nid, t
  typedef struct packed {
    evt_op_e                op;
    logic [EVT_GID_W-1:0]   gid;
    logic [EVT_NID_W-1:0]   nid;
    timestamp_t             t;
  } spike_evt_t;

  // Encoder FSM states
  typedef logic [1:0] enc_state_t;
  localparam enc_state_t ENC_IDLE   = 2'd0;
  localparam enc_state_t ENC_SEND   = 2'd1;
  localparam enc_state_t ENC_EOS    = 2'd2;
  localparam enc_state_t ENC_RETIRE = 2'd3;

  // Event word width for a given group/neuron index geometry
  function automatic int unsigned evt_width(input int unsigned gid_w,
                                            input int unsigned nid_w);
    return 2 + gid_w + nid_w + TIME_W;
  endfunction

endpackage

// File: rtl/SNE_EVENT_STREAM.sv
// SNE event stream: valid/ready handshake carrying one event word per beat.
// src modport drives valid/data and samples ready; dst is the mirror image.
interface SNE_EVENT_STREAM #(
  parameter int unsigned DATA_W = 30
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport src (output valid, output data, input ready);
  modport dst (input valid, input data, output ready);

endinterface

// File: rtl/evt_spike_encoder_lzc.sv
// Leading/trailing zero counter (common_cells lzc compatible).
// Ports:
//   in_i    - vector to scan
//   cnt_o   - MODE=0: index of lowest set bit; MODE=1: number of leading zeros
//   empty_o - in_i is all zero (cnt_o is then 0)
module evt_spike_encoder_lzc #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Priority scan: the last hit in loop order is the one nearest the counted end
  always_comb begin
    cnt_o = '0;
    if (MODE) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(int'(WIDTH) - 1 - i);
      end
    end else begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/evt_spike_encoder.sv
// Spike vector to event stream serializer for one neuron group.
// Captures per-timestep spike vectors into an active/shadow double buffer and
// emits one SPIKE event per set bit (ascending nid), optionally followed by an
// end-of-step event, on an SNE_EVENT_STREAM source port.
// Ports:
//   clk_i, rst_i     - clock, asynchronous active-high reset
//   spike_i          - spike flags of the group's neurons
//   spike_valid_i    - capture strobe for spike_i/time_i
//   time_i           - timestamp of the captured timestep
//   group_id_i       - static group index placed in every event
//   eos_en_i         - append an EOS event after each drained vector
//   evt_stream_src   - output event stream (valid/ready/data)
//   busy_o           - buffers hold data or FSM is not idle (registered)
//   overflow_o       - one-cycle pulse when a captured vector was dropped
module evt_spike_encoder
  import sne_evt_stream_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 16,
  parameter int unsigned NID_W       = $clog2(NUM_NEURONS),
  parameter int unsigned GID_W       = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_NEURONS-1:0] spike_i,
  input  logic                   spike_valid_i,
  input  timestamp_t             time_i,
  input  logic [GID_W-1:0]       group_id_i,
  input  logic                   eos_en_i,
  SNE_EVENT_STREAM.src           evt_stream_src,
  output logic                   busy_o,
  output logic                   overflow_o
);

  localparam int unsigned EVT_W = evt_width(GID_W, NID_W);

  // Active buffer (being drained) and shadow buffer (next timestep)
  logic [NUM_NEURONS-1:0] vec_a_q, vec_a_d;
  timestamp_t             t_a_q,   t_a_d;
  logic                   full_a_q, full_a_d;
  logic [NUM_NEURONS-1:0] vec_s_q, vec_s_d;
  timestamp_t             t_s_q,   t_s_d;
  logic                   full_s_q, full_s_d;

  enc_state_t             state_q, state_d;
  logic                   valid_q, valid_d;
  logic [EVT_W-1:0]       data_q,  data_d;
  logic                   busy_q,  busy_d;
  logic                   overflow_q, overflow_d;

  logic                   hs_c;
  logic                   cap_en_c;
  logic                   retire_c;
  logic [NUM_NEURONS-1:0] lzc_in_c;
  logic [NID_W-1:0]       lzc_cnt_c;
  logic                   lzc_empty_c;

  function automatic logic [EVT_W-1:0] pack_evt(input evt_op_e          op,
                                                input logic [GID_W-1:0] gid,
                                                input logic [NID_W-1:0] nid,
                                                input timestamp_t       t);
    return {op, gid, nid, t};
  endfunction

  assign hs_c     = valid_q && evt_stream_src.ready;
  assign cap_en_c = spike_valid_i && ((|spike_i) || eos_en_i);

  // In SEND the selector looks one event ahead: the active vector with the
  // currently presented (lowest) bit already removed. Elsewhere it sees vec_a.
  assign lzc_in_c = (state_q == ENC_SEND) ? (vec_a_q & (vec_a_q - NUM_NEURONS'(1)))
                                          : vec_a_q;

  evt_spike_encoder_lzc #(
    .WIDTH     (NUM_NEURONS),
    .MODE      (1'b0),
    .CNT_WIDTH (NID_W)
  ) u_lzc (
    .in_i    (lzc_in_c),
    .cnt_o   (lzc_cnt_c),
    .empty_o (lzc_empty_c)
  );

  // Next-state, buffer and output computation
  always_comb begin
    state_d    = state_q;
    vec_a_d    = vec_a_q;
    t_a_d      = t_a_q;
    full_a_d   = full_a_q;
    vec_s_d    = vec_s_q;
    t_s_d      = t_s_q;
    full_s_d   = full_s_q;
    valid_d    = valid_q;
    data_d     = data_q;
    overflow_d = 1'b0;
    retire_c   = 1'b0;

    case (state_q)
      ENC_IDLE: begin
        if (full_a_q) begin
          if (!lzc_empty_c) begin
            state_d = ENC_SEND;
            valid_d = 1'b1;
            data_d  = pack_evt(EVT_SPIKE, group_id_i, lzc_cnt_c, t_a_q);
          end else if (eos_en_i) begin
            state_d = ENC_EOS;
            valid_d = 1'b1;
            data_d  = pack_evt(EVT_EOS, group_id_i, '0, t_a_q);
          end else begin
            // Empty vector whose EOS is no longer wanted: just free it
            state_d = ENC_RETIRE;
          end
        end
      end

      ENC_SEND: begin
        if (hs_c) begin
          vec_a_d = lzc_in_c;
          if (!lzc_empty_c) begin
            data_d = pack_evt(EVT_SPIKE, group_id_i, lzc_cnt_c, t_a_q);
          end else if (eos_en_i) begin
            state_d = ENC_EOS;
            data_d  = pack_evt(EVT_EOS, group_id_i, '0, t_a_q);
          end else begin
            state_d = ENC_RETIRE;
            valid_d = 1'b0;
          end
        end
      end

      ENC_EOS: begin
        if (hs_c) begin
          state_d = ENC_RETIRE;
          valid_d = 1'b0;
        end
      end

      ENC_RETIRE: begin
        retire_c = 1'b1;
        full_a_d = 1'b0;
        if (full_s_q) begin
          vec_a_d  = vec_s_q;
          t_a_d    = t_s_q;
          full_a_d = 1'b1;
          full_s_d = 1'b0;
        end
        state_d = ENC_IDLE;
      end

      default: begin
        state_d = ENC_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Capture; a retiring active buffer frees a slot in this same cycle
    if (cap_en_c) begin
      if (!full_a_q || (retire_c && !full_s_q)) begin
        vec_a_d  = spike_i;
        t_a_d    = time_i;
        full_a_d = 1'b1;
      end else if (!full_s_q || retire_c) begin
        vec_s_d  = spike_i;
        t_s_d    = time_i;
        full_s_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    busy_d = full_a_d || full_s_d || (state_d != ENC_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ENC_IDLE;
      vec_a_q    <= '0;
      t_a_q      <= '0;
      full_a_q   <= 1'b0;
      vec_s_q    <= '0;
      t_s_q      <= '0;
      full_s_q   <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_a_q    <= vec_a_d;
      t_a_q      <= t_a_d;
      full_a_q   <= full_a_d;
      vec_s_q    <= vec_s_d;
      t_s_q      <= t_s_d;
      full_s_q   <= full_s_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_stream_src.valid = valid_q;
  assign evt_stream_src.data  = data_q;
  assign busy_o               = busy_q;
  assign overflow_o           = overflow_q;

endmodule

// File: tb/tb_evt_spike_encoder.sv
// Testbench for evt_spike_encoder: directed scenarios plus randomized traffic,
// checked against a vector-level reference model (event FIFO + slot counting).
module tb_evt_spike_encoder;
  import sne_evt_stream_pkg::*;

  localparam int unsigned NN = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned GW = 8;
  localparam int unsigned EW = $bits(spike_evt_t);

  logic          clk;
  logic          rst;
  logic [NN-1:0] spike;
  logic          spike_vld;
  timestamp_t    tstamp;
  logic [GW-1:0] gid;
  logic          eos_en;
  logic          busy;
  logic          ovf;

  SNE_EVENT_STREAM #(.DATA_W(EW)) ev ();

  evt_spike_encoder #(
    .NUM_NEURONS (NN),
    .NID_W       (NW),
    .GID_W       (GW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .spike_i        (spike),
    .spike_valid_i  (spike_vld),
    .time_i         (tstamp),
    .group_id_i     (gid),
    .eos_en_i       (eos_en),
    .evt_stream_src (ev),
    .busy_o         (busy),
    .overflow_o     (ovf)
  );

  int n_chk;
  int n_err;
  int cyc;
  int rdy_mode;   // 0: always 1, 1: pattern 1,0,0,1, 2: random, 3: always 0

  // Reference model state
  spike_evt_t    exp_q[$];
  bit            exp_last[$];
  int            accepted;
  int            retired;
  bit            exp_ovf;
  int            hs_cnt;
  int            ovf_cnt;
  logic          pv;
  logic          pr;
  logic [EW-1:0] pdata;

  logic [NN-1:0] rv;
  int            lat;
  int            base_hs;
  int            base_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [NN-1:0] v, input timestamp_t t);
    spike     = v;
    tstamp    = t;
    spike_vld = 1'b1;
    step();
    spike_vld = 1'b0;
  endtask

  // Expected events of one accepted vector, ascending nid, optional EOS
  task automatic push_vector(input logic [NN-1:0] v, input timestamp_t t);
    spike_evt_t e;
    for (int i = 0; i < int'(NN); i++) begin
      if (v[i]) begin
        e.op  = EVT_SPIKE;
        e.gid = gid;
        e.nid = NW'(i);
        e.t   = t;
        exp_q.push_back(e);
        exp_last.push_back(1'b0);
      end
    end
    if (eos_en) begin
      e.op  = EVT_EOS;
      e.gid = gid;
      e.nid = '0;
      e.t   = t;
      exp_q.push_back(e);
      exp_last.push_back(1'b0);
    end
    exp_last[exp_last.size() - 1] = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    check_eq("drain_queue", 64'(exp_q.size()), 64'd0);
    check_eq("drain_busy", 64'(busy), 64'd0);
  endtask

  // Ready driver
  initial begin
    ev.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ev.ready = 1'b1;
        1:       ev.ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       ev.ready = ($urandom_range(0, 3) != 0);
        default: ev.ready = 1'b0;
      endcase
    end
  end

  // Monitor and reference model, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_last.delete();
        accepted = 0;
        retired  = 0;
        exp_ovf  = 1'b0;
        pv       = 1'b0;
        continue;
      end
      check_eq("overflow", 64'(ovf), 64'(exp_ovf));
      if (ovf) ovf_cnt++;
      exp_ovf = 1'b0;
      if (pv && !pr) begin
        check_eq("hold_valid", 64'(ev.valid), 64'd1);
        check_eq("hold_data", 64'(ev.data), 64'(pdata));
      end
      // A vector occupies a slot until the cycle after its last event
      if (spike_vld && ((spike != '0) || eos_en)) begin
        if (accepted - retired >= 2) begin
          exp_ovf = 1'b1;
        end else begin
          accepted++;
          push_vector(spike, tstamp);
        end
      end
      if (ev.valid && ev.ready) begin
        hs_cnt++;
        check_eq("evt_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          check_eq("evt_data", 64'(ev.data), 64'(exp_q[0]));
          if (exp_last[0]) retired++;
          void'(exp_q.pop_front());
          void'(exp_last.pop_front());
        end
      end
      pv    = ev.valid;
      pr    = ev.ready;
      pdata = ev.data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; rdy_mode = 0;
    hs_cnt = 0; ovf_cnt = 0;
    rst = 1'b1; spike = '0; spike_vld = 1'b0; tstamp = '0; gid = 8'd3; eos_en = 1'b0;
    repeat (3) step();
    check_eq("rst_valid", 64'(ev.valid), 64'd0);
    check_eq("rst_data", 64'(ev.data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    repeat (2) step();

    // Single vector: latency, order, busy release after RETIRE
    base_hs = hs_cnt;
    send_vec(16'h8005, 16'h0012);
    lat = 1;
    while (!ev.valid && lat < 10) begin
      step();
      lat++;
    end
    check_eq("t1_latency", 64'(lat), 64'd2);
    repeat (3) step();
    check_eq("t1_retire_valid", 64'(ev.valid), 64'd0);
    check_eq("t1_retire_busy", 64'(busy), 64'd1);
    step();
    check_eq("t1_busy_fall", 64'(busy), 64'd0);
    check_eq("t1_count", 64'(hs_cnt - base_hs), 64'd3);

    // Same vector under back-pressure
    rdy_mode = 1;
    base_hs = hs_cnt;
    send_vec(16'h8005, 16'h0012);
    wait_idle(200);
    check_eq("t2_count", 64'(hs_cnt - base_hs), 64'd3);
    rdy_mode = 0;
    step();

    // Empty vector with and without EOS
    eos_en = 1'b1;
    base_hs = hs_cnt;
    send_vec(16'h0000, 16'h0007);
    wait_idle(200);
    check_eq("t3_eos_count", 64'(hs_cnt - base_hs), 64'd1);
    eos_en = 1'b0;
    base_hs = hs_cnt;
    send_vec(16'h0000, 16'h0008);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_busy_idle", 64'(busy), 64'd0);
      step();
    end
    check_eq("t3_no_events", 64'(hs_cnt - base_hs), 64'd0);

    // Three back-to-back vectors while stalled: third is dropped
    rdy_mode = 3;
    step();
    step();
    base_hs  = hs_cnt;
    base_ovf = ovf_cnt;
    send_vec(16'h0003, 16'h0001);
    send_vec(16'h0010, 16'h0002);
    send_vec(16'h0100, 16'h0003);
    repeat (4) step();
    check_eq("t4_ovf_count", 64'(ovf_cnt - base_ovf), 64'd1);
    rdy_mode = 0;
    wait_idle(200);
    check_eq("t4_count", 64'(hs_cnt - base_hs), 64'd3);

    // Capture landing on RETIRE while the shadow is full
    base_hs  = hs_cnt;
    base_ovf = ovf_cnt;
    send_vec(16'h0003, 16'h0021);
    send_vec(16'h0010, 16'h0022);
    step();
    step();
    check_eq("t5_retire_gap", 64'(ev.valid), 64'd0);
    send_vec(16'h0200, 16'h0023);
    wait_idle(200);
    check_eq("t5_no_ovf", 64'(ovf_cnt - base_ovf), 64'd0);
    check_eq("t5_count", 64'(hs_cnt - base_hs), 64'd4);

    // Reset in the middle of a vector
    send_vec(16'h8005, 16'h0030);
    step();
    step();
    rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 64'(ev.valid), 64'd0);
    check_eq("t6_rst_busy", 64'(busy), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    base_hs = hs_cnt;
    send_vec(16'h0002, 16'h0031);
    wait_idle(200);
    check_eq("t6_count", 64'(hs_cnt - base_hs), 64'd1);

    // Randomized traffic, EOS off then on
    for (int ph = 0; ph < 2; ph++) begin
      eos_en   = (ph == 1);
      gid      = 8'($urandom);
      rdy_mode = 2;
      for (int k = 0; k < 40; k++) begin
        case ($urandom_range(0, 3))
          0:       rv = '0;
          1:       rv = NN'(32'd1 << $urandom_range(0, NN - 1));
          default: rv = NN'($urandom) & NN'($urandom);
        endcase
        send_vec(rv, timestamp_t'($urandom));
        repeat ($urandom_range(0, 6)) step();
      end
      wait_idle(3000);
      rdy_mode = 0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
